// File: rtl/seq_divider_32by16_if.sv
// Operand/result bundle for the sequential divider.
// Handshake rule for both sides: a transfer happens on a rising clock edge
// where valid and ready are both 1. Once valid is raised, the payload is held
// stable until that edge. Ready never depends combinationally on valid.
interface seq_divider_32by16_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;
    logic                 overflow;

    // Divider side
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    // Requester side
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider_32by16.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock. Divide-by-zero and quotient overflow are
// detected up front and answered after a single cycle.
module seq_divider_32by16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,       // asynchronous, active-high
    seq_divider_32by16_if.slave bus,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_rem;       // partial remainder, one guard bit
    logic [WIDTH-1:0]   r_q;         // low dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   r_divisor;

    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;
    logic               r_ovf;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_zero;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH:0]     w_t;
    logic               w_ge;
    logic [WIDTH:0]     w_rem_next;
    logic [WIDTH-1:0]   w_q_next;
    logic               w_last;

    assign w_accept   = bus.in_valid && (r_state == IDLE);
    assign w_hi       = bus.dividend[2*WIDTH-1:WIDTH];
    assign w_zero     = (bus.divisor == '0);
    // A quotient fits in WIDTH bits only when the high half is below the divisor.
    assign w_ovf      = !w_zero && (w_hi >= bus.divisor);

    assign w_t        = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_ge       = (w_t >= {1'b0, r_divisor});
    assign w_rem_next = w_ge ? (w_t - {1'b0, r_divisor}) : w_t;
    assign w_q_next   = {r_q[WIDTH-2:0], w_ge};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = r_out_valid;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;
    assign o_dbg_state     = r_state;

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_zero || w_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_dbz       <= 1'b1;
                            r_ovf       <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else if (w_ovf) begin
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_dbz       <= 1'b0;
                            r_ovf       <= 1'b1;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt     <= '0;
                            r_rem     <= {1'b0, w_hi};
                            r_q       <= bus.dividend[WIDTH-1:0];
                            r_divisor <= bus.divisor;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next[WIDTH-1:0];
                        r_dbz       <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_32by16.sv
// Randomized self-checking bench for seq_divider_32by16 against an
// arithmetic reference model (integer / and %).
module tb_seq_divider_32by16;
  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seq_divider_32by16_if #(.WIDTH(W)) bus ();
  logic [1:0] dbg_state;

  seq_divider_32by16 #(.WIDTH(W), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // expected result: {quotient, remainder, div_by_zero, overflow}
  logic [2*W+1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2*W+1:0] model(input logic [2*W-1:0] dd, input logic [W-1:0] ds);
    longint unsigned a, b, q, r;
    a = dd;
    b = ds;
    if (b == 0) return {{W{1'b1}}, {W{1'b0}}, 1'b1, 1'b0};
    q = a / b;
    r = a % b;
    if (q > 64'(2**W - 1)) return {{W{1'b1}}, {W{1'b0}}, 1'b0, 1'b1};
    return {q[W-1:0], r[W-1:0], 2'b00};
  endfunction

  task automatic check_result(input logic [2*W+1:0] e);
    check("out_valid",   bus.out_valid,   1);
    check("quotient",    bus.quotient,    e[2*W+1:W+2]);
    check("remainder",   bus.remainder,   e[W+1:2]);
    check("div_by_zero", bus.div_by_zero, e[1]);
    check("overflow",    bus.overflow,    e[0]);
    check("in_ready_busy", bus.in_ready,  0);
  endtask

  // driver: one full operation with a given number of out_ready stall cycles
  task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] ds, input int stall);
    logic [2*W+1:0] e;
    int guard;
    int edges;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", bus.in_ready, 1);
    exp_q.push_back(model(dd, ds));
    bus.in_valid = 1'b1;
    bus.dividend = dd;
    bus.divisor  = ds;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
    // edges counted after the accept edge; errors show valid right after it
    edges = 0;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    e = exp_q.pop_front();
    check("latency", edges, (e[1] | e[0]) ? 0 : W);
    check_result(e);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_result(e);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_after", bus.in_ready, 1);
    check("quotient_held", bus.quotient, e[2*W+1:W+2]);
  endtask

  initial begin
    logic [31:0] a, b;
    int guard;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_quotient",  bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz",       bus.div_by_zero, 0);
    check("rst_ovf",       bus.overflow, 0);
    rst_n = 1'b0;

    // product round-trips and boundaries
    run_op(32'd1743104, 16'd1238, 0);
    run_op(32'd101727396, 16'd10086, 1);
    run_op(32'hFFFE0001, 16'hFFFF, 0);
    run_op(32'd101727401, 16'd10086, 0);
    // error paths
    run_op(32'd1234, 16'd0, 0);
    run_op(32'h00010000, 16'd1, 0);
    // back-pressure
    run_op(32'd5000000, 16'd777, 20);

    // reset in the middle of iteration
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.dividend = 32'd1743104;
    bus.divisor  = 16'd1238;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_quotient",  bus.quotient, 0);
    check("mid_rst_remainder", bus.remainder, 0);
    check("mid_rst_dbz",       bus.div_by_zero, 0);
    check("mid_rst_ovf",       bus.overflow, 0);
    check("mid_rst_in_ready",  bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b0;
    run_op(32'd1743104, 16'd1238, 2);

    // random: mostly products a*b, some arbitrary pairs including errors
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        a = $urandom_range(0, 65535);
        b = $urandom_range(1, 65535);
        run_op(a * b, b[W-1:0], $urandom_range(0, 3));
      end else begin
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
        run_op(a, b[W-1:0], $urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // hard stop in case something wedges outside the bounded waits
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
